// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I-subset control FSM: sequences one instruction over several clocks
// on a shared-memory datapath, with memory handshake, bus timeout and trap causes.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_cond,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       retired,
  output logic       illegal,
  output logic       bus_err
);
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_bus_err;
  logic             w_mem_state;
  logic             w_wait;
  logic             w_timeout;
  logic             w_known;
  logic             w_set_ill;
  logic             w_set_bus;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_wait      = w_mem_state && !mem_ready;
  // The cycle whose stall would make the count reach MEM_TIMEOUT is the trapping one
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_wait && (r_cnt == CNT_LAST);
  assign w_known     = opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_bus = 1'b0;
    case (r_state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          w_next = (r_state == S_FETCH)  ? S_DECODE :
                   (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          default: begin
            w_next    = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
            w_set_ill = ILLEGAL_TRAP;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      S_MEM_ADDR:         w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: w_next = S_FETCH;
      S_TRAP:             w_next = S_TRAP;
      default:            w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus_err <= 1'b1;
    end
  end

  // Write enables in FETCH are also gated by rst_n so nothing loads while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    retired    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        retired   = !w_known && !ILLEGAL_TRAP;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retired    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        retired = mem_ready;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = branch_cond;
        retired   = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_src     = 2'b01;
        pc_write   = 1'b1;
        retired    = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b10;
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        retired    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, hand-written corner
// sequences and a randomized run against an instruction-path reference model.
module tb_multicycle_control_unit;
  localparam int N = 3;
  localparam int TO_P [N] = '{16, 4, 0};
  localparam bit IT_P [N] = '{1'b1, 1'b1, 1'b0};

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, retired, pc_src, mem_to_reg}
  localparam logic [10:0] C_NONE = 11'b0000000_00_00;
  localparam logic [10:0] C_FRDY = 11'b1001100_00_00;
  localparam logic [10:0] C_FWT  = 11'b1000000_00_00;
  localparam logic [10:0] C_AWB  = 11'b0000011_00_00;
  localparam logic [10:0] C_RD   = 11'b1010000_00_00;
  localparam logic [10:0] C_MWB  = 11'b0000011_00_01;
  localparam logic [10:0] C_BR1  = 11'b0000101_01_00;
  localparam logic [10:0] C_BR0  = 11'b0000001_01_00;
  localparam logic [10:0] C_JAL  = 11'b0000111_01_10;
  localparam logic [10:0] C_JALR = 11'b0000111_10_10;
  localparam logic [10:0] C_WR0  = 11'b1110000_00_00;
  localparam logic [10:0] C_WR1  = 11'b1110001_00_00;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
    logic [1:0] m2r, a, b, op, pcs;
    logic       retired, illegal, bus_err;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        bc;
    logic [3:0]  st;
    logic [10:0] ctl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n       [N];
  logic [6:0] opcode      [N];
  logic       mem_ready   [N];
  logic       branch_cond [N];
  logic       mem_req [N], mem_we [N], i_or_d [N], ir_write [N], pc_write [N], reg_write [N];
  logic       retired [N], illegal [N], bus_err [N];
  logic [1:0] mem_to_reg [N], alu_src_a [N], alu_src_b [N], alu_op [N], pc_src [N];
  logic [3:0] state [N];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the state path of the current instruction and a position in it
  int m_path [N][5];
  int m_len  [N];
  int m_pos  [N];
  int m_wait [N];
  bit m_trap [N];
  bit m_ill  [N];
  bit m_bus  [N];

  vec_t tbl [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    multicycle_control_unit #(
      .MEM_TIMEOUT (TO_P[gi]),
      .ILLEGAL_TRAP(IT_P[gi])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[gi]),
      .opcode     (opcode[gi]),
      .mem_ready  (mem_ready[gi]),
      .branch_cond(branch_cond[gi]),
      .mem_req    (mem_req[gi]),
      .mem_we     (mem_we[gi]),
      .i_or_d     (i_or_d[gi]),
      .ir_write   (ir_write[gi]),
      .pc_write   (pc_write[gi]),
      .reg_write  (reg_write[gi]),
      .mem_to_reg (mem_to_reg[gi]),
      .alu_src_a  (alu_src_a[gi]),
      .alu_src_b  (alu_src_b[gi]),
      .alu_op     (alu_op[gi]),
      .pc_src     (pc_src[gi]),
      .state      (state[gi]),
      .retired    (retired[gi]),
      .illegal    (illegal[gi]),
      .bus_err    (bus_err[gi])
    );
  end

  function automatic outs_t act(int k);
    outs_t o;
    o.st = state[k];       o.mem_req = mem_req[k];   o.mem_we = mem_we[k];
    o.i_or_d = i_or_d[k];  o.ir_write = ir_write[k]; o.pc_write = pc_write[k];
    o.reg_write = reg_write[k]; o.m2r = mem_to_reg[k]; o.a = alu_src_a[k];
    o.b = alu_src_b[k];    o.op = alu_op[k];         o.pcs = pc_src[k];
    o.retired = retired[k]; o.illegal = illegal[k];  o.bus_err = bus_err[k];
    return o;
  endfunction

  function automatic void add(logic r, logic [6:0] op, logic rdy, logic bc, logic [3:0] st,
                              logic [10:0] ctl);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.bc = bc; v.st = st; v.ctl = ctl;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
    end
  endtask

  // Drive every instance identically at the falling edge; outputs settle by #1
  task automatic step(logic r, logic [6:0] op, logic rdy, logic bc);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      rst_n[k] = r; opcode[k] = op; mem_ready[k] = rdy; branch_cond[k] = bc;
    end
    #1;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_BAD, 7'b0110111};
    return ops[$urandom_range(8)];
  endfunction

  function automatic void model_reset(int k);
    m_path[k] = '{0, 0, 0, 0, 0};
    m_len[k] = 1; m_pos[k] = 0; m_wait[k] = 0;
    m_trap[k] = 1'b0; m_ill[k] = 1'b0; m_bus[k] = 1'b0;
  endfunction

  function automatic void build_path(int k);
    case (opcode[k])
      OP_R:    begin m_path[k] = '{0, 1, 2, 8, 0};  m_len[k] = 4; end
      OP_I:    begin m_path[k] = '{0, 1, 3, 8, 0};  m_len[k] = 4; end
      OP_LW:   begin m_path[k] = '{0, 1, 4, 5, 6};  m_len[k] = 5; end
      OP_SW:   begin m_path[k] = '{0, 1, 4, 7, 0};  m_len[k] = 4; end
      OP_BR:   begin m_path[k] = '{0, 1, 9, 0, 0};  m_len[k] = 3; end
      OP_JAL:  begin m_path[k] = '{0, 1, 10, 0, 0}; m_len[k] = 3; end
      OP_JALR: begin m_path[k] = '{0, 1, 11, 0, 0}; m_len[k] = 3; end
      default: begin
        m_path[k] = '{0, 1, 12, 0, 0};
        m_len[k]  = IT_P[k] ? 3 : 2;
      end
    endcase
  endfunction

  // Advance one clock edge: memory steps stall on !ready, others move along the path
  function automatic void model_step(int k);
    int s;
    if (m_trap[k]) return;
    s = m_path[k][m_pos[k]];
    if ((s == 0 || s == 5 || s == 7) && !mem_ready[k]) begin
      m_wait[k]++;
      if (TO_P[k] != 0 && m_wait[k] == TO_P[k]) begin
        m_trap[k] = 1'b1; m_bus[k] = 1'b1;
      end
      return;
    end
    m_wait[k] = 0;
    if (s == 0) begin
      build_path(k);
      m_pos[k] = 1;
    end else begin
      m_pos[k]++;
      if (m_pos[k] >= m_len[k]) m_pos[k] = 0;
    end
    if (m_path[k][m_pos[k]] == 12) begin
      m_trap[k] = 1'b1; m_ill[k] = 1'b1;
    end
  endfunction

  function automatic outs_t expect_outs(int k);
    outs_t o;
    int    s;
    logic  rdy;
    o   = '0;
    s   = m_trap[k] ? 12 : m_path[k][m_pos[k]];
    rdy = mem_ready[k];
    o.st = 4'(s); o.illegal = m_ill[k]; o.bus_err = m_bus[k];
    case (s)
      0:  begin o.mem_req = 1'b1; o.b = 2'b01; o.ir_write = rdy & rst_n[k]; o.pc_write = rdy & rst_n[k]; end
      1:  begin o.a = 2'b01; o.b = 2'b10; end
      2:  begin o.a = 2'b10; o.op = 2'b10; end
      3:  begin o.a = 2'b10; o.b = 2'b10; o.op = 2'b10; end
      4:  begin o.a = 2'b10; o.b = 2'b10; end
      5:  begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
      6:  begin o.reg_write = 1'b1; o.m2r = 2'b01; end
      7:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.i_or_d = 1'b1; end
      8:  o.reg_write = 1'b1;
      9:  begin o.a = 2'b10; o.op = 2'b01; o.pcs = 2'b01; o.pc_write = branch_cond[k]; end
      10: begin o.reg_write = 1'b1; o.m2r = 2'b10; o.pcs = 2'b01; o.pc_write = 1'b1; end
      11: begin o.a = 2'b10; o.b = 2'b10; o.pcs = 2'b10; o.pc_write = 1'b1; o.reg_write = 1'b1; o.m2r = 2'b10; end
      default: ;
    endcase
    // An instruction retires on the last step of its path, once any memory handshake completes
    o.retired = !m_trap[k] && rst_n[k] && (m_pos[k] > 0) && (m_pos[k] == m_len[k] - 1) &&
                (!(s == 5 || s == 7) || rdy);
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; opcode[k] = OP_R; mem_ready[k] = 1'b0; branch_cond[k] = 1'b0;
    end

    add(0, OP_R, 1, 0, 0, C_FWT);
    add(1, OP_R, 1, 0, 0, C_FRDY); add(1, OP_R, 1, 0, 1, C_NONE);
    add(1, OP_R, 1, 0, 2, C_NONE); add(1, OP_R, 1, 0, 8, C_AWB);
    add(1, OP_LW, 1, 0, 0, C_FRDY); add(1, OP_LW, 1, 0, 1, C_NONE); add(1, OP_LW, 1, 0, 4, C_NONE);
    add(1, OP_LW, 0, 0, 5, C_RD); add(1, OP_LW, 0, 0, 5, C_RD); add(1, OP_LW, 0, 0, 5, C_RD);
    add(1, OP_LW, 1, 0, 5, C_RD); add(1, OP_LW, 1, 0, 6, C_MWB);
    add(1, OP_BR, 1, 1, 0, C_FRDY); add(1, OP_BR, 1, 1, 1, C_NONE); add(1, OP_BR, 1, 1, 9, C_BR1);
    add(1, OP_BR, 1, 0, 0, C_FRDY); add(1, OP_BR, 1, 0, 1, C_NONE); add(1, OP_BR, 1, 0, 9, C_BR0);
    add(1, OP_JAL, 1, 0, 0, C_FRDY); add(1, OP_JAL, 1, 0, 1, C_NONE); add(1, OP_JAL, 1, 0, 10, C_JAL);
    add(1, OP_JALR, 1, 0, 0, C_FRDY); add(1, OP_JALR, 1, 0, 1, C_NONE); add(1, OP_JALR, 1, 0, 11, C_JALR);
    add(1, OP_SW, 1, 0, 0, C_FRDY); add(1, OP_SW, 1, 0, 1, C_NONE); add(1, OP_SW, 1, 0, 4, C_NONE);
    add(1, OP_SW, 0, 0, 7, C_WR0); add(1, OP_SW, 1, 0, 7, C_WR1);
    add(1, OP_I, 0, 0, 0, C_FWT); add(1, OP_I, 1, 0, 0, C_FRDY); add(1, OP_I, 1, 0, 1, C_NONE);
    add(1, OP_I, 1, 0, 3, C_NONE); add(1, OP_I, 1, 0, 8, C_AWB); add(1, OP_I, 1, 0, 0, C_FRDY);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].bc);
      chk($sformatf("vec%0d_state_ctl", i),
          32'({state[0], mem_req[0], mem_we[0], i_or_d[0], ir_write[0], pc_write[0],
               reg_write[0], retired[0], pc_src[0], mem_to_reg[0]}),
          32'({tbl[i].st, tbl[i].ctl}));
    end

    // Unknown opcode: trap instances hold TRAP, the NOP instance retires from DECODE
    step(0, OP_BAD, 1, 0);
    step(1, OP_BAD, 1, 0);
    step(1, OP_BAD, 1, 0);
    chk("illegal_nop_retired", 32'(retired[2]), 32'd1);
    chk("illegal_decode_state", 32'(state[0]), 32'd1);
    step(1, OP_BAD, 1, 0);
    chk("illegal_nop_back_to_fetch", 32'({state[2], illegal[2]}), 32'({4'd0, 1'b0}));
    for (int c = 0; c < 22; c++) begin
      step(1, OP_BAD, 1, 0);
      chk($sformatf("trap_hold_c%0d", c),
          32'({state[0], illegal[0], mem_req[0], pc_write[0], retired[0]}),
          32'({4'd12, 1'b1, 1'b0, 1'b0, 1'b0}));
    end
    step(0, OP_BAD, 1, 0);
    chk("trap_cleared_by_reset", 32'({state[0], illegal[0], mem_req[0]}), 32'({4'd0, 1'b0, 1'b1}));

    // Fetch timeout with MEM_TIMEOUT=4 on instance 1
    step(0, OP_R, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(1, OP_R, 0, 0);
      chk($sformatf("timeout_wait_c%0d", c), 32'({state[1], bus_err[1]}), 32'({4'd0, 1'b0}));
    end
    step(1, OP_R, 0, 0);
    chk("timeout_trap", 32'({state[1], bus_err[1]}), 32'({4'd12, 1'b1}));
    chk("timeout16_no_trap", 32'({state[0], bus_err[0]}), 32'({4'd0, 1'b0}));
    chk("timeout_disabled", 32'({state[2], bus_err[2]}), 32'({4'd0, 1'b0}));
    step(0, OP_R, 0, 0);
    for (int c = 0; c < 3; c++) step(1, OP_R, 0, 0);
    step(1, OP_R, 1, 0);
    step(1, OP_R, 1, 0);
    chk("ready_beats_timeout", 32'({state[1], bus_err[1]}), 32'({4'd1, 1'b0}));

    // Store stalled in MEM_WR, reset pulsed in the middle of the cycle
    step(0, OP_SW, 1, 0);
    step(1, OP_SW, 1, 0);
    step(1, OP_SW, 1, 0);
    step(1, OP_SW, 1, 0);
    step(1, OP_SW, 0, 0);
    chk("sw_stalled", 32'({state[0], mem_we[0], retired[0]}), 32'({4'd7, 1'b1, 1'b0}));
    #2;
    for (int k = 0; k < N; k++) rst_n[k] = 1'b0;
    #1;
    chk("sw_abort_by_reset", 32'({state[0], mem_we[0], retired[0], mem_req[0]}),
        32'({4'd0, 1'b0, 1'b0, 1'b1}));
    step(1, OP_SW, 0, 0);
    chk("sw_abort_after_release", 32'({state[0], retired[0]}), 32'({4'd0, 1'b0}));

    // Randomized run, each instance with its own inputs, against the path model
    step(0, OP_R, 0, 0);
    for (int k = 0; k < N; k++) model_reset(k);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!rst_n[k]) rst_n[k] = 1'b1;
        else           rst_n[k] = ($urandom_range(m_trap[k] ? 9 : 199) != 0);
        mem_ready[k]   = ($urandom_range(9) < 7);
        branch_cond[k] = 1'($urandom_range(1));
        if (m_pos[k] == 0 && !m_trap[k]) opcode[k] = pick_op();
        if (!rst_n[k]) model_reset(k);
      end
      #1;
      for (int k = 0; k < N; k++) begin
        outs_t e;
        outs_t a;
        e = expect_outs(k);
        a = act(k);
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL rand c%0d inst%0d: got 0x%06h, want 0x%06h (op %b rdy %b)",
                   c, k, a, e, opcode[k], mem_ready[k]);
        end
        if (rst_n[k]) model_step(k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
